layer6_packer: RTL and testbench
================================

# layer6_packer

Write-side packer for the layer-6 local buffer. It accepts a stream of 16-bit layer-6 results from the convolution output stage and groups every 8 consecutive results into one 128-bit word. Each completed word is written into the 64×128 dual-port layer-6 SRAM through its port A. It sits directly upstream of the layer-6 SRAM wrapper; port B of that SRAM is left to the downstream layer-7 reader.

## Interface
Parameters:
- DATA_W, 16, width of one result
- LANES, 8, results per SRAM word (LANES×DATA_W = 128)
- DEPTH, 64, SRAM words
- AW, 6, SRAM address width

Ports:
- clk  in  1  single clock for the block
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a layer; accepted only in IDLE or DONE
- in_valid  in  1  in_data is valid
- in_data  in  DATA_W  result, two's-complement
- in_last  in  1  qualifies the final result of the layer
- in_ready  out  1  block accepts a beat this cycle
- sram_A  out  AW  port-A word address
- sram_DIA  out  128  port-A write data
- sram_WEAN  out  1  port-A write enable, active low
- sram_OEA  out  1  port-A output enable; always 0
- word_cnt  out  AW+1  words written since the last start
- done  out  1  one-cycle pulse at layer completion
- overflow  out  1  sticky; more than DEPTH words were offered

## Operation
- A beat is accepted when in_valid && in_ready.
- States and transitions:
  - IDLE → PACK on start.
  - PACK → FLUSH on an accepted in_last that leaves a partial word.
  - PACK → DONE after the final word is written.
  - FLUSH → DONE.
  - DONE → PACK on start.
- On start: lane counter, sram address, word_cnt and overflow are cleared.
- start while in PACK or FLUSH is ignored.
- in_ready = 1 only in PACK.
- Lane packing:
  - The first result of a word occupies bits [15:0]; lane k occupies [16k+15:16k].
  - The lane counter counts 0..7 and wraps to 0.
- Word completion: the accepted beat in lane 7 completes the word. The word is written on the next cycle: sram_WEAN=0, sram_A=address, sram_DIA=word. The address then increments and word_cnt increments.
- Partial flush: an accepted in_last in lane k<7 is handled in FLUSH. The block pads lanes k+1..7 with zero and writes the word one cycle after the in_last beat.
- The packer never back-pressures within a word. Packing the next word overlaps the write of the previous one.
- Capacity:
  - When the DEPTH-th word is written, the block goes to DONE regardless of in_last.
  - If that final beat did not carry in_last, overflow is set.
  - in_ready is 0 from the cycle after that beat.
- Outputs are registered.

## Timing
- Reset values: in_ready=0, sram_A=0, sram_DIA=0, sram_WEAN=1, sram_OEA=0, word_cnt=0, done=0, overflow=0. State is IDLE and the lane counter is 0.
- start accepted at cycle t → in_ready=1 at t+1.
- Lane-7 beat at cycle t → sram_WEAN low for exactly cycle t+1. word_cnt updates at t+2.
- Final beat at cycle t (a lane-7 beat, or in_last in any lane) → write at t+1, done pulse at t+2.
- done pulses only once per layer.
- Asserting rst mid-layer returns every output to its reset value immediately. Partial data is discarded and no write is issued.
- in_valid while in_ready=0 is not consumed; the source holds the beat.

## Configuration
- LAYER6_PACK_RELU_EN:
  - Defined: each accepted result with in_data[DATA_W-1]=1 is stored as 0 (ReLU fused before packing).
  - Undefined: in_data is stored unmodified.
- Padding lanes are zero either way.

## Test plan
- Start, then 16 beats 0x0001..0x0010, last on the 16th:
  - Write at A=0: DIA=0x0008_0007_0006_0005_0004_0003_0002_0001.
  - Write at A=1: DIA with 0x0010 in the top lane.
  - word_cnt=2, one done pulse, overflow=0.
- Three beats 0xAAAA, 0xBBBB, 0xCCCC, last on the third:
  - One write at A=0 with DIA=0x…0000_CCCC_BBBB_AAAA (upper 80 bits zero).
  - done two cycles after the third beat.
- 512 continuous beats, last on beat 512:
  - 64 writes at A=0..63, with sram_WEAN low one cycle each.
  - word_cnt=64, overflow=0, in_ready never drops before DONE.
- 513 beats offered with no in_last:
  - After the 64th write: DONE, overflow=1, in_ready=0, beat 513 is not consumed.
  - A new start clears overflow.
- rst asserted after 5 beats of a word:
  - No write issued; all outputs at reset values.
  - A fresh start then packs from lane 0 at A=0.
- With LAYER6_PACK_RELU_EN defined, 8 beats 0x8001, 0x7FFF, 0xFFFF, 0x0001, 0, 0, 0, 0:
  - Lanes read 0, 0x7FFF, 0, 0x0001, 0, 0, 0, 0.
  - Without the macro, the raw values are stored.

Source files
------------

// File: rtl/layer6_packer.sv
// Layer-6 write-side packer: groups LANES consecutive DATA_W-bit results into one
// SRAM word and writes it through port A of the layer-6 buffer.
// Optional feature macro: LAYER6_PACK_RELU_EN (negative results stored as zero).
module layer6_packer #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned LANES  = 8,
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned AW     = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    in_valid,
   input  logic [DATA_W-1:0]       in_data,
   input  logic                    in_last,
   output logic                    in_ready,
   output logic [AW-1:0]           sram_A,
   output logic [LANES*DATA_W-1:0] sram_DIA,
   output logic                    sram_WEAN,
   output logic                    sram_OEA,
   output logic [AW:0]             word_cnt,
   output logic                    done,
   output logic                    overflow
);

   localparam int unsigned WordW = LANES * DATA_W;
   localparam int unsigned LaneW = $clog2(LANES);
   localparam int unsigned CntW  = AW + 1;
   localparam logic [LaneW-1:0] LastLane = LaneW'(LANES - 1);
   localparam logic [CntW-1:0]  LastWord = CntW'(DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StPack, StFlush, StDone} state_e;

   state_e            r_state;
   logic [LaneW-1:0]  r_lane;
   logic [WordW-1:0]  r_word;
   logic              r_final;
   logic              r_in_ready;
   logic [AW-1:0]     r_addr;
   logic [WordW-1:0]  r_dia;
   logic              r_wean;
   logic [CntW-1:0]   r_word_cnt;
   logic              r_done;
   logic              r_overflow;

   logic [DATA_W-1:0] w_data;
   logic [WordW-1:0]  w_word;
   logic              w_accept;
   logic              w_full;

   assign w_accept = in_valid & r_in_ready;
   // This word is the last one the SRAM can hold.
   assign w_full   = (r_word_cnt == LastWord);

   // Value actually stored for the incoming result.
   always_comb begin
`ifdef LAYER6_PACK_RELU_EN
      w_data = in_data[DATA_W-1] ? '0 : in_data;
`else
      w_data = in_data;
`endif
   end

   // Current word with the incoming result dropped into its lane; upper lanes stay zero.
   always_comb begin
      w_word = r_word;
      for (int k = 0; k < LANES; k++) begin
         if (r_lane == LaneW'(k)) begin
            w_word[k*DATA_W +: DATA_W] = w_data;
         end
      end
   end

   // Control FSM with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StIdle;
         r_lane     <= '0;
         r_word     <= '0;
         r_final    <= 1'b0;
         r_in_ready <= 1'b0;
         r_addr     <= '0;
         r_dia      <= '0;
         r_wean     <= 1'b1;
         r_word_cnt <= '0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_wean <= 1'b1;
         r_done <= 1'b0;
         // A write issued last cycle has now landed: advance address and count.
         if (!r_wean) begin
            r_addr     <= r_addr + AW'(1);
            r_word_cnt <= r_word_cnt + CntW'(1);
         end
         case (r_state)
            StIdle, StDone: begin
               if (start) begin
                  r_state    <= StPack;
                  r_in_ready <= 1'b1;
                  r_lane     <= '0;
                  r_word     <= '0;
                  r_final    <= 1'b0;
                  r_addr     <= '0;
                  r_word_cnt <= '0;
                  r_overflow <= 1'b0;
               end
            end
            StPack: begin
               if (r_final) begin
                  // Final full word was written this cycle.
                  r_state <= StDone;
                  r_done  <= 1'b1;
                  r_final <= 1'b0;
               end else if (w_accept) begin
                  if (r_lane == LastLane) begin
                     r_dia  <= w_word;
                     r_wean <= 1'b0;
                     r_word <= '0;
                     r_lane <= '0;
                     if (in_last || w_full) begin
                        r_final    <= 1'b1;
                        r_in_ready <= 1'b0;
                        if (!in_last) begin
                           r_overflow <= 1'b1;
                        end
                     end
                  end else if (in_last) begin
                     // Partial word: lanes above this one are already zero.
                     r_dia      <= w_word;
                     r_wean     <= 1'b0;
                     r_word     <= '0;
                     r_lane     <= '0;
                     r_in_ready <= 1'b0;
                     r_state    <= StFlush;
                  end else begin
                     r_word <= w_word;
                     r_lane <= r_lane + LaneW'(1);
                  end
               end
            end
            StFlush: begin
               r_state <= StDone;
               r_done  <= 1'b1;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign sram_A    = r_addr;
   assign sram_DIA  = r_dia;
   assign sram_WEAN = r_wean;
   assign sram_OEA  = 1'b0;
   assign word_cnt  = r_word_cnt;
   assign done      = r_done;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_layer6_packer.sv
// Self-checking bench for layer6_packer: queue-based word model plus per-cycle compare.
module tb_layer6_packer;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned LANES  = 8;
   localparam int unsigned DEPTH  = 64;
   localparam int unsigned AW     = 6;
   localparam int unsigned WORD_W = LANES * DATA_W;

   logic              clk;
   logic              rst;
   logic              start;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              in_ready;
   logic [AW-1:0]     sram_A;
   logic [WORD_W-1:0] sram_DIA;
   logic              sram_WEAN;
   logic              sram_OEA;
   logic [AW:0]       word_cnt;
   logic              done;
   logic              overflow;

   layer6_packer #(
      .DATA_W(DATA_W),
      .LANES (LANES),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_last  (in_last),
      .in_ready (in_ready),
      .sram_A   (sram_A),
      .sram_DIA (sram_DIA),
      .sram_WEAN(sram_WEAN),
      .sram_OEA (sram_OEA),
      .word_cnt (word_cnt),
      .done     (done),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int                cyc;
      logic [AW-1:0]     addr;
      logic [WORD_W-1:0] data;
   } wr_t;

   wr_t               exp_q[$];
   logic [DATA_W-1:0] cur_q[$];
   logic [DATA_W-1:0] stim[$];
   logic [AW-1:0]     log_a[$];
   logic [WORD_W-1:0] log_d[$];
   int  n_chk = 0;
   int  n_fail = 0;
   int  m_addr = 0;
   int  m_words = 0;
   int  exp_done_cyc = -10;
   int  done_seen = 0;
   int  obs_cnt = 0;
   int  stalls = 0;
   bit  layer_end = 0;
   bit  m_over = 0;
   bit  exp_wr;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, req);
      end
   endtask

   function automatic logic [DATA_W-1:0] model_store(input logic [DATA_W-1:0] d);
`ifdef LAYER6_PACK_RELU_EN
      return d[DATA_W-1] ? '0 : d;
`else
      return d;
`endif
   endfunction

   task automatic model_begin();
      exp_q.delete();
      cur_q.delete();
      log_a.delete();
      log_d.delete();
      m_addr       = 0;
      m_words      = 0;
      exp_done_cyc = -10;
      done_seen    = 0;
      stalls       = 0;
      layer_end    = 0;
      m_over       = 0;
   endtask

   // Beat accepted in cycle c: collect results; a full or last group becomes a write at c+1.
   task automatic model_beat(input logic [DATA_W-1:0] d, input logic last, input int c);
      wr_t w;
      cur_q.push_back(model_store(d));
      if (cur_q.size() == LANES || last) begin
         w.data = '0;
         foreach (cur_q[i]) w.data[i*DATA_W +: DATA_W] = cur_q[i];
         w.addr = m_addr[AW-1:0];
         w.cyc  = c + 1;
         exp_q.push_back(w);
         cur_q.delete();
         m_addr++;
         m_words++;
         if (last || m_words == DEPTH) begin
            exp_done_cyc = c + 2;
            m_over       = !last;
            layer_end    = 1;
         end
      end
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (!rst) begin
         chk("sram_OEA", sram_OEA, 1'b0);
         chk("word_cnt", word_cnt, obs_cnt);
         exp_wr = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
         chk("sram_WEAN", sram_WEAN, !exp_wr);
         if (!sram_WEAN) begin
            log_a.push_back(sram_A);
            log_d.push_back(sram_DIA);
         end
         if (exp_wr) begin
            chk("sram_A", sram_A, exp_q[0].addr);
            chk("sram_DIA", sram_DIA, exp_q[0].data);
            void'(exp_q.pop_front());
            obs_cnt++;
         end
         chk("done", done, cyc == exp_done_cyc);
         if (done) done_seen++;
      end
   end

   task automatic do_start();
      model_begin();
      start = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      obs_cnt = 0;
      chk("in_ready_after_start", in_ready, 1'b1);
      chk("overflow_after_start", overflow, 1'b0);
   endtask

   task automatic drive(input int last_idx);
      int waited;
      for (int i = 0; i < stim.size(); i++) begin
         if (layer_end) break;
         in_valid = 1'b1;
         in_data  = stim[i];
         in_last  = (i == last_idx);
         waited   = 0;
         @(negedge clk);
         while (!in_ready && waited < 20) begin
            waited++;
            stalls++;
            @(negedge clk);
         end
         if (!in_ready) begin
            chk("in_ready_wait", in_ready, 1'b1);
            break;
         end
         model_beat(stim[i], in_last, cyc);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (cyc <= exp_done_cyc + 1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("done_count", done_seen, 1);
      chk("writes_left", exp_q.size(), 0);
      chk("in_ready_in_done", in_ready, 1'b0);
      chk("overflow_final", overflow, m_over);
      chk("word_cnt_final", word_cnt, m_words);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_sram_A", sram_A, 0);
      chk("rst_sram_DIA", sram_DIA, 0);
      chk("rst_sram_WEAN", sram_WEAN, 1'b1);
      chk("rst_sram_OEA", sram_OEA, 1'b0);
      chk("rst_word_cnt", word_cnt, 0);
      chk("rst_done", done, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      #1;
      chk_reset_outputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Two full words, last on the 16th beat.
      do_start();
      stim.delete();
      for (int i = 1; i <= 16; i++) stim.push_back(16'(i));
      drive(15);
      wait_done();
      chk("t1_writes", log_a.size(), 2);
      if (log_a.size() == 2) begin
         chk("t1_a0", log_a[0], 0);
         chk("t1_d0", log_d[0], 128'h0008_0007_0006_0005_0004_0003_0002_0001);
         chk("t1_a1", log_a[1], 1);
         chk("t1_d1", log_d[1], 128'h0010_000F_000E_000D_000C_000B_000A_0009);
      end

      // Partial word, zero padded.
      do_start();
      stim.delete();
      stim.push_back(16'hAAAA);
      stim.push_back(16'hBBBB);
      stim.push_back(16'hCCCC);
      drive(2);
      wait_done();
      chk("t2_writes", log_a.size(), 1);
      if (log_a.size() == 1) begin
         chk("t2_a0", log_a[0], 0);
         chk("t2_d0", log_d[0], 128'h0000_0000_0000_0000_0000_CCCC_BBBB_AAAA);
      end

      // Exactly full buffer, last on beat 512.
      do_start();
      stim.delete();
      for (int i = 0; i < 512; i++) stim.push_back(16'(i * 7 + 3));
      drive(511);
      wait_done();
      chk("t3_stalls", stalls, 0);
      chk("t3_writes", log_a.size(), 64);
      if (log_a.size() == 64) chk("t3_a63", log_a[63], 63);

      // Overflow: 513 beats offered without in_last.
      do_start();
      stim.delete();
      for (int i = 0; i < 513; i++) stim.push_back(16'(i) ^ 16'h5A5A);
      drive(-1);
      wait_done();
      chk("t4_overflow", overflow, 1'b1);
      in_valid = 1'b1;
      in_data  = stim[512];
      repeat (4) begin
         @(negedge clk);
         chk("t4_beat513_held", in_ready, 1'b0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("t4_writes", log_a.size(), 64);
      do_start();

      // Reset after 5 beats of a word.
      stim.delete();
      for (int i = 0; i < 5; i++) stim.push_back(16'h1000 + 16'(i));
      drive(-1);
      rst = 1'b1;
      #1;
      chk_reset_outputs();
      @(posedge clk);
      #1;
      rst     = 1'b0;
      obs_cnt = 0;
      model_begin();
      do_start();
      stim.delete();
      for (int i = 1; i <= 8; i++) stim.push_back(16'h0100 + 16'(i));
      drive(7);
      wait_done();
      chk("t5_writes", log_a.size(), 1);
      if (log_a.size() == 1) begin
         chk("t5_a0", log_a[0], 0);
         chk("t5_d0", log_d[0], 128'h0108_0107_0106_0105_0104_0103_0102_0101);
      end

      // Sign handling of stored results.
      do_start();
      stim.delete();
      stim.push_back(16'h8001);
      stim.push_back(16'h7FFF);
      stim.push_back(16'hFFFF);
      stim.push_back(16'h0001);
      for (int i = 0; i < 4; i++) stim.push_back(16'h0000);
      drive(7);
      wait_done();
      chk("t6_writes", log_a.size(), 1);
      if (log_a.size() == 1) begin
`ifdef LAYER6_PACK_RELU_EN
         chk("t6_d0", log_d[0], 128'h0000_0000_0000_0000_0001_0000_7FFF_0000);
`else
         chk("t6_d0", log_d[0], 128'h0000_0000_0000_0000_0001_FFFF_7FFF_8001);
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
